blob_centroid_tracker: RTL and testbench

- Consumes the 1-bit thresholded pixel stream from the camera capture stage: write strobe, pixel bit and end-of-frame pulse, in the same clock domain.
- Accumulates per-frame statistics of foreground pixels: count, coordinate sums and bounding box.
- At end of frame, runs a sequential divide to produce the centroid.
- Results feed the tracking/actuation logic downstream.

---
 rtl/cam_pkg.sv | 18 +
 rtl/seq_divider.sv | 64 ++++++
 rtl/blob_centroid_tracker.sv | 185 ++++++++++++++++++
 tb/tb_blob_centroid_tracker.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared image geometry, datapath widths and FSM states for the blob centroid path.
package cam_pkg;

  localparam int unsigned IMG_W = 320;
  localparam int unsigned IMG_H = 240;

  localparam int unsigned X_W   = 9;
  localparam int unsigned Y_W   = 8;
  localparam int unsigned CNT_W = 17;
  localparam int unsigned SUM_W = 25;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; divisor 0 is treated as 1.
module seq_divider #(
  parameter int unsigned DVD_W  = 25,
  parameter int unsigned DVSR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DVD_W-1:0]  dividend,
  input  logic [DVSR_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DVD_W-1:0]  quotient
);

  localparam int unsigned ITER_W = $clog2(DVD_W + 1);

  logic [DVSR_W-1:0] rem;
  logic [DVSR_W-1:0] dvsr;
  logic [ITER_W-1:0] iter;
  logic [DVSR_W:0]   shifted;
  logic [DVSR_W:0]   diff;

  // Remainder stays below the divisor, so the MSB of diff is a clean borrow flag.
  always_comb begin
    shifted = {rem, quotient[DVD_W-1]};
    diff    = shifted - {1'b0, dvsr};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem      <= '0;
      dvsr     <= '0;
      iter     <= '0;
      quotient <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        rem      <= '0;
        quotient <= dividend;
        dvsr     <= (divisor == '0) ? DVSR_W'(1) : divisor;
        iter     <= '0;
        busy     <= 1'b1;
      end else if (busy) begin
        if (!diff[DVSR_W]) begin
          rem      <= diff[DVSR_W-1:0];
          quotient <= {quotient[DVD_W-2:0], 1'b1};
        end else begin
          rem      <= shifted[DVSR_W-1:0];
          quotient <= {quotient[DVD_W-2:0], 1'b0};
        end
        if (iter == ITER_W'(DVD_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          iter <= iter + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/blob_centroid_tracker.sv
// Per-frame foreground statistics (count, coordinate sums, bbox) and centroid via sequential divide.
module blob_centroid_tracker #(
  parameter int unsigned IMG_W      = cam_pkg::IMG_W,
  parameter int unsigned IMG_H      = cam_pkg::IMG_H,
  parameter int unsigned MIN_PIXELS = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pix_valid,
  input  logic                      pix_data,
  input  logic                      frame_done,
  output logic                      result_valid,
  output logic                      target_found,
  output logic [cam_pkg::X_W-1:0]   centroid_x,
  output logic [cam_pkg::Y_W-1:0]   centroid_y,
  output logic [cam_pkg::CNT_W-1:0] fg_count,
  output logic [cam_pkg::X_W-1:0]   bbox_xmin,
  output logic [cam_pkg::X_W-1:0]   bbox_xmax,
  output logic [cam_pkg::Y_W-1:0]   bbox_ymin,
  output logic [cam_pkg::Y_W-1:0]   bbox_ymax,
  output logic                      busy,
  output logic                      overrun
);

  import cam_pkg::*;

  state_t           state;
  logic [X_W-1:0]   x_pos;
  logic [Y_W-1:0]   y_pos;
  logic [CNT_W-1:0] cnt, cnt_nxt, snap_cnt;
  logic [SUM_W-1:0] sx, sy, sx_nxt, sy_nxt;
  logic [X_W-1:0]   xmin, xmax, xmin_nxt, xmax_nxt, snap_xmin, snap_xmax;
  logic [Y_W-1:0]   ymin, ymax, ymin_nxt, ymax_nxt, snap_ymin, snap_ymax;
  logic             pix_in, fg, accept, div_start, found;
  logic             dx_busy, dy_busy, dx_done, dy_done;
  logic [SUM_W-1:0] qx, qy;
  logic [X_W-1:0]   cx_sat;
  logic [Y_W-1:0]   cy_sat;

  // The *_nxt values include a pixel coincident with frame_done, so the snapshot sees it.
  always_comb begin
    pix_in    = pix_valid && (y_pos != Y_W'(IMG_H));
    fg        = pix_in && pix_data;
    accept    = frame_done && (state == IDLE);
    div_start = accept && !dx_busy && !dy_busy;
    cnt_nxt   = cnt;
    sx_nxt    = sx;
    sy_nxt    = sy;
    xmin_nxt  = xmin;
    xmax_nxt  = xmax;
    ymin_nxt  = ymin;
    ymax_nxt  = ymax;
    if (fg) begin
      cnt_nxt = cnt + 1'b1;
      sx_nxt  = sx + SUM_W'(x_pos);
      sy_nxt  = sy + SUM_W'(y_pos);
      if (x_pos < xmin) xmin_nxt = x_pos;
      if (x_pos > xmax) xmax_nxt = x_pos;
      if (y_pos < ymin) ymin_nxt = y_pos;
      if (y_pos > ymax) ymax_nxt = y_pos;
    end
    found  = (snap_cnt >= CNT_W'(MIN_PIXELS));
    cx_sat = (|qx[SUM_W-1:X_W]) ? '1 : qx[X_W-1:0];
    cy_sat = (|qy[SUM_W-1:Y_W]) ? '1 : qy[Y_W-1:0];
  end

  seq_divider #(.DVD_W(SUM_W), .DVSR_W(CNT_W)) u_div_x (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (sx_nxt),
    .divisor  (cnt_nxt),
    .busy     (dx_busy),
    .done     (dx_done),
    .quotient (qx)
  );

  seq_divider #(.DVD_W(SUM_W), .DVSR_W(CNT_W)) u_div_y (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (sy_nxt),
    .divisor  (cnt_nxt),
    .busy     (dy_busy),
    .done     (dy_done),
    .quotient (qy)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_pos <= '0;
      y_pos <= '0;
      cnt   <= '0;
      sx    <= '0;
      sy    <= '0;
      xmin  <= '1;
      xmax  <= '0;
      ymin  <= '1;
      ymax  <= '0;
    end else if (frame_done) begin
      x_pos <= '0;
      y_pos <= '0;
      cnt   <= '0;
      sx    <= '0;
      sy    <= '0;
      xmin  <= '1;
      xmax  <= '0;
      ymin  <= '1;
      ymax  <= '0;
    end else begin
      cnt  <= cnt_nxt;
      sx   <= sx_nxt;
      sy   <= sy_nxt;
      xmin <= xmin_nxt;
      xmax <= xmax_nxt;
      ymin <= ymin_nxt;
      ymax <= ymax_nxt;
      if (pix_in) begin
        if (x_pos == X_W'(IMG_W - 1)) begin
          x_pos <= '0;
          y_pos <= y_pos + 1'b1;
        end else begin
          x_pos <= x_pos + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      result_valid <= 1'b0;
      target_found <= 1'b0;
      centroid_x   <= '0;
      centroid_y   <= '0;
      fg_count     <= '0;
      bbox_xmin    <= '0;
      bbox_xmax    <= '0;
      bbox_ymin    <= '0;
      bbox_ymax    <= '0;
      snap_cnt     <= '0;
      snap_xmin    <= '0;
      snap_xmax    <= '0;
      snap_ymin    <= '0;
      snap_ymax    <= '0;
    end else begin
      result_valid <= 1'b0;
      if ((pix_valid && !pix_in) || (frame_done && (state != IDLE)))
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            snap_cnt  <= cnt_nxt;
            snap_xmin <= xmin_nxt;
            snap_xmax <= xmax_nxt;
            snap_ymin <= ymin_nxt;
            snap_ymax <= ymax_nxt;
            busy      <= 1'b1;
            state     <= DIV;
          end
        end
        DIV: begin
          if (dx_done && dy_done) state <= DONE;
        end
        DONE: begin
          result_valid <= 1'b1;
          target_found <= found;
          fg_count     <= snap_cnt;
          centroid_x   <= found ? cx_sat : '0;
          centroid_y   <= found ? cy_sat : '0;
          bbox_xmin    <= found ? snap_xmin : '0;
          bbox_xmax    <= found ? snap_xmax : '0;
          bbox_ymin    <= found ? snap_ymin : '0;
          bbox_ymax    <= found ? snap_ymax : '0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blob_centroid_tracker.sv
// Scoreboard bench: two instances (MIN_PIXELS 1 and 16) share one pixel stream.
module tb_blob_centroid_tracker;

  localparam int W = 320;
  localparam int H = 240;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pix_valid = 1'b0, pix_data = 1'b0, frame_done = 1'b0;

  logic        a_rv, a_found, a_busy, a_ovr;
  logic [8:0]  a_cx, a_xmin, a_xmax;
  logic [7:0]  a_cy, a_ymin, a_ymax;
  logic [16:0] a_cnt;
  logic        b_rv, b_found, b_busy, b_ovr;
  logic [8:0]  b_cx, b_xmin, b_xmax;
  logic [7:0]  b_cy, b_ymin, b_ymax;
  logic [16:0] b_cnt;

  blob_centroid_tracker #(.IMG_W(W), .IMG_H(H), .MIN_PIXELS(1)) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data), .frame_done(frame_done),
    .result_valid(a_rv), .target_found(a_found), .centroid_x(a_cx), .centroid_y(a_cy),
    .fg_count(a_cnt), .bbox_xmin(a_xmin), .bbox_xmax(a_xmax), .bbox_ymin(a_ymin),
    .bbox_ymax(a_ymax), .busy(a_busy), .overrun(a_ovr)
  );

  blob_centroid_tracker #(.IMG_W(W), .IMG_H(H), .MIN_PIXELS(16)) dut16 (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data), .frame_done(frame_done),
    .result_valid(b_rv), .target_found(b_found), .centroid_x(b_cx), .centroid_y(b_cy),
    .fg_count(b_cnt), .bbox_xmin(b_xmin), .bbox_xmax(b_xmax), .bbox_ymin(b_ymin),
    .bbox_ymax(b_ymax), .busy(b_busy), .overrun(b_ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt, sx, sy, xmin, xmax, ymin, ymax, due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   rv_count = 0;
  int   busy_until = -1000;
  int   m_x, m_y, m_cnt, m_sx, m_sy, m_xmin, m_xmax, m_ymin, m_ymax;
  logic exp_ovr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (a_rv === 1'b1) rv_count <= rv_count + 1;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  task automatic model_clear();
    m_x = 0; m_y = 0; m_cnt = 0; m_sx = 0; m_sy = 0;
    m_xmin = 511; m_xmax = 0; m_ymin = 255; m_ymax = 0;
  endtask

  // Drive one cycle of inputs and advance the reference model for the edge that samples them.
  task automatic drive(input logic v, input logic d, input logic fd);
    exp_t e;
    @(negedge clk);
    pix_valid = v; pix_data = d; frame_done = fd;
    if (v) begin
      if (m_y == H) exp_ovr = 1'b1;
      else begin
        if (d) begin
          m_cnt++; m_sx += m_x; m_sy += m_y;
          if (m_x < m_xmin) m_xmin = m_x;
          if (m_x > m_xmax) m_xmax = m_x;
          if (m_y < m_ymin) m_ymin = m_y;
          if (m_y > m_ymax) m_ymax = m_y;
        end
        if (m_x == W - 1) begin m_x = 0; m_y++; end
        else m_x++;
      end
    end
    if (fd) begin
      if (cyc + 1 <= busy_until) exp_ovr = 1'b1;
      else begin
        e.cnt = m_cnt; e.sx = m_sx; e.sy = m_sy;
        e.xmin = m_xmin; e.xmax = m_xmax; e.ymin = m_ymin; e.ymax = m_ymax;
        e.due = cyc + 1 + 27;
        sb.push_back(e);
        busy_until = cyc + 1 + 27;
      end
      model_clear();
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_run(input int n, input logic d);
    for (int i = 0; i < n; i++) drive(1'b1, d, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; pix_valid = 1'b0; pix_data = 1'b0; frame_done = 1'b0;
    sb.delete(); busy_until = -1000; exp_ovr = 1'b0; model_clear();
    #1;
    tests++;
    if ({a_rv, a_found, a_cx, a_cy, a_cnt, a_xmin, a_xmax, a_ymin, a_ymax, a_busy, a_ovr} !== '0) begin
      $display("FAIL reset_outputs: got rv=%0d found=%0d cx=%0d cy=%0d cnt=%0d busy=%0d ovr=%0d required all 0",
               a_rv, a_found, a_cx, a_cy, a_cnt, a_busy, a_ovr);
      fails++;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_result(input string name);
    bit got;
    exp_t ex;
    int cx, cy;
    logic fa, fb;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      idle();
      if (a_rv === 1'b1) got = 1;
    end
    tests++;
    if (!got) begin
      $display("FAIL %s_timeout: result_valid not seen within 60 cycles, required a pulse", name);
      fails++;
      return;
    end
    tests++;
    if (sb.size() == 0) begin
      $display("FAIL %s_unexpected: result_valid with empty scoreboard, required none", name);
      fails++;
      return;
    end
    ex = sb.pop_front();
    cx = (ex.cnt == 0) ? 0 : ex.sx / ex.cnt;
    cy = (ex.cnt == 0) ? 0 : ex.sy / ex.cnt;
    if (cx > 511) cx = 511;
    if (cy > 255) cy = 255;
    fa = (ex.cnt >= 1);
    fb = (ex.cnt >= 16);

    tests++;
    if (cyc !== ex.due) begin
      $display("FAIL %s_latency: result at cycle %0d, required %0d", name, cyc, ex.due); fails++;
    end
    tests++;
    if (a_found !== fa) begin
      $display("FAIL %s_found: got %0d required %0d", name, a_found, fa); fails++;
    end
    tests++;
    if (a_cnt !== 17'(ex.cnt)) begin
      $display("FAIL %s_fg_count: got %0d required %0d", name, a_cnt, ex.cnt); fails++;
    end
    tests++;
    if ({a_cx, a_cy} !== (fa ? {9'(cx), 8'(cy)} : 17'd0)) begin
      $display("FAIL %s_centroid: got (%0d,%0d) required (%0d,%0d)", name, a_cx, a_cy,
               fa ? cx : 0, fa ? cy : 0); fails++;
    end
    tests++;
    if ({a_xmin, a_xmax, a_ymin, a_ymax} !==
        (fa ? {9'(ex.xmin), 9'(ex.xmax), 8'(ex.ymin), 8'(ex.ymax)} : 34'd0)) begin
      $display("FAIL %s_bbox: got (%0d,%0d,%0d,%0d) required (%0d,%0d,%0d,%0d)", name,
               a_xmin, a_xmax, a_ymin, a_ymax,
               fa ? ex.xmin : 0, fa ? ex.xmax : 0, fa ? ex.ymin : 0, fa ? ex.ymax : 0); fails++;
    end
    tests++;
    if ({b_rv, b_found, b_cnt, b_cx, b_cy, b_xmin, b_xmax, b_ymin, b_ymax} !==
        {1'b1, fb, 17'(ex.cnt), fb ? {9'(cx), 8'(cy), 9'(ex.xmin), 9'(ex.xmax), 8'(ex.ymin), 8'(ex.ymax)} : 51'd0}) begin
      $display("FAIL %s_min16: got rv=%0d found=%0d cnt=%0d cx=%0d cy=%0d required rv=1 found=%0d cnt=%0d cx=%0d cy=%0d",
               name, b_rv, b_found, b_cnt, b_cx, b_cy, fb, ex.cnt, fb ? cx : 0, fb ? cy : 0); fails++;
    end
    tests++;
    if (a_ovr !== exp_ovr) begin
      $display("FAIL %s_overrun: got %0d required %0d", name, a_ovr, exp_ovr); fails++;
    end
    idle();
    tests++;
    if (a_rv !== 1'b0) begin
      $display("FAIL %s_pulse_width: result_valid got %0d one cycle later, required 0", name, a_rv); fails++;
    end
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_single_pixel();
    send_run(3 * W + 5, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    send_run(W - 6, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    idle();
    tests++;
    if (a_busy !== 1'b1) begin
      $display("FAIL single_busy: got %0d required 1", a_busy); fails++;
    end
    wait_result("single");
  endtask

  task automatic test_zero_frame();
    send_run(100, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    wait_result("zero");
  endtask

  task automatic test_small_blob();
    send_run(10, 1'b0);
    send_run(10, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    wait_result("blob10");
  endtask

  task automatic test_coincident();
    send_run(3, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    wait_result("coincident");
  endtask

  task automatic test_full_frame();
    send_run(W * H, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    wait_result("full");
  endtask

  task automatic test_reset_mid_div();
    int rv0;
    send_run(20, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    repeat (10) idle();
    rv0 = rv_count;
    apply_reset();
    repeat (40) idle();
    tests++;
    if (rv_count !== rv0) begin
      $display("FAIL middiv_no_result: result_valid pulses got %0d required 0", rv_count - rv0); fails++;
    end
    for (int i = 0; i < 2 * W + 17; i++) drive(1'b1, (i % 7) == 3, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    wait_result("after_reset");
  endtask

  task automatic test_back_to_back();
    int rv0;
    rv0 = rv_count;
    send_run(1, 1'b0);
    send_run(2, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    repeat (4) idle();
    drive(1'b0, 1'b0, 1'b1);
    wait_result("b2b_first");
    repeat (10) idle();
    tests++;
    if (rv_count - rv0 !== 1) begin
      $display("FAIL b2b_single_result: result_valid pulses got %0d required 1", rv_count - rv0); fails++;
    end
    send_run(5, 1'b0);
    send_run(20, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    wait_result("b2b_next");
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_pixel();
    test_zero_frame();
    test_small_blob();
    test_coincident();
    test_full_frame();
    test_reset_mid_div();
    test_back_to_back();
    repeat (5) idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
